channel_model: RTL and testbench
================================

CHANNEL_MODEL -- requirements
Module: channel_model

Interface
REQ-001 Parameter DATA_W, default 16, symbol component width (two's complement).
REQ-002 Parameter SEED, default 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; clears all state when 0.
REQ-005 in_valid  input  1  qualifies in_re/in_im/config for one symbol per cycle.
REQ-006 in_re, in_im  input  DATA_W  signed QPSK symbol from transmit stage.
REQ-007 cfg_mode  input  2  0 bypass, 1 additive noise, 2 burst inversion, 3 noise+burst.
REQ-008 noise_shift  input  4  left-shift applied to 8-bit noise samples, 0..8 valid; >8 treated as 8.
REQ-009 burst_period  input  16  clean symbols between bursts; 0 disables bursts.
REQ-010 burst_len  input  8  symbols per burst; 0 disables bursts.
REQ-011 out_valid  output  1  qualifies out_re/out_im.
REQ-012 out_re, out_im  output  DATA_W  impaired signed symbol to receive stage.
REQ-013 sym_count  output  32  accepted symbols, saturating at all-ones.
REQ-014 burst_count  output  16  symbols inverted by burst logic, saturating at all-ones.

Function
REQ-015 Symbol accepted on any cycle with in_valid=1; no backpressure; config sampled with the symbol.
REQ-016 Fixed latency 2: out_valid SHALL equal in_valid delayed 2 cycles; bubbles preserved exactly.
REQ-017 Noise source: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing once per accepted symbol, after its value is used.
REQ-018 noise_re = signed(lfsr[15:8]) and noise_im = signed(lfsr[7:0]), sign-extended to DATA_W+9 bits, then shifted left by noise_shift.
REQ-019 Modes 1/3: component = in + noise, computed at full width, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-020 Modes 0/2: noise not added; the LFSR SHALL still advance per accepted symbol.
REQ-021 Burst FSM states CLEAN and BURST with a 16-bit symbol counter; counts only accepted symbols.
REQ-022 CLEAN: after burst_period accepted symbols, go to BURST with counter cleared; the symbol that completes the count is clean.
REQ-023 BURST: each accepted symbol has both components negated; after burst_len symbols, return to CLEAN with counter cleared.
REQ-024 Negation saturates: most-negative value maps to most-positive; applied after noise addition.
REQ-025 If cfg_mode is 0/1, or burst_period=0, or burst_len=0 on an accepted symbol: FSM forced to CLEAN, counter cleared, that symbol not inverted.
REQ-026 burst_count increments once per inverted symbol, in the same cycle its result enters stage 2.
REQ-027 Pipeline: stage 1 registers the symbol, noise, and invert flag; stage 2 registers the saturated result to the outputs.

Reset
REQ-028 While reset=0: out_valid=0, out_re=out_im=0, lfsr=SEED, FSM=CLEAN, counter=0, sym_count=0, burst_count=0.
REQ-029 Reset assertion mid-stream SHALL discard in-flight symbols; out_valid is 0 on the first two cycles after release unless new symbols arrive.
REQ-030 Reset release is synchronised internally (async assert, sync deassert).

Verification
REQ-031 Bypass: mode 0, in_re=16'h4000, in_im=16'hC000, one valid pulse -> out 16'h4000/16'hC000 exactly 2 cycles later, sym_count=1.
REQ-032 Noise with saturation: after reset, mode 1, noise_shift=8, in_re=16'h8000, in_im=16'h0000 -> out_re=16'h8000 (-84*256 saturated), out_im=16'hE100 (-31*256).
REQ-033 Burst: mode 2, period 4, len 2, in_re=16'h1000 for 12 symbols -> symbols 5,6,11,12 give 16'hF000, all others 16'h1000; burst_count=4.
REQ-034 Negation edge: mode 2, period 1, len 1, in_re=16'h8000 on symbol 2 -> out_re=16'h7FFF.
REQ-035 Reset mid-burst: assert reset during BURST with 2 symbols in flight -> outputs 0, counters 0, the next symbol after release passes clean; LFSR restarts from SEED.
REQ-036 Bubbles: in_valid pattern 1,0,1,1 -> out_valid 0,0,1,0,1,1; LFSR advances 3 times.

Source files
------------

// File: rtl/channel_model.sv
// Baseband channel impairment model: LFSR-driven additive noise and periodic
// burst inversion applied to a QPSK symbol stream through a two-stage pipeline.
`timescale 1ns/1ps

module channel_model #(
    parameter int          DATA_W = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic [1:0]        cfg_mode,
    input  logic [3:0]        noise_shift,
    input  logic [15:0]       burst_period,
    input  logic [7:0]        burst_len,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [31:0]       sym_count,
    output logic [15:0]       burst_count,
    output logic              burst_state
);

    localparam int NW = DATA_W + 9;
    localparam int SW = DATA_W + 10;

    typedef enum logic {
        CLEAN = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    // Reset: asserts asynchronously, releases two clock edges later.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Noise source
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (in_valid) begin
            lfsr <= lfsr_next;
        end
    end

    logic [3:0]            shift_eff;
    logic signed [NW-1:0]  noise_re_ext;
    logic signed [NW-1:0]  noise_im_ext;
    logic signed [NW-1:0]  noise_re_sh;
    logic signed [NW-1:0]  noise_im_sh;

    assign shift_eff    = (noise_shift > 4'd8) ? 4'd8 : noise_shift;
    assign noise_re_ext = {{(NW-8){lfsr[15]}}, lfsr[15:8]};
    assign noise_im_ext = {{(NW-8){lfsr[7]}}, lfsr[7:0]};
    assign noise_re_sh  = noise_re_ext <<< shift_eff;
    assign noise_im_sh  = noise_im_ext <<< shift_eff;

    // Burst FSM
    burst_state_t state_q;
    burst_state_t state_d;
    logic [15:0]  cnt_q;
    logic [15:0]  cnt_d;
    logic [16:0]  cnt_inc;
    logic         invert;
    logic         burst_off;

    assign cnt_inc   = {1'b0, cnt_q} + 17'd1;
    assign burst_off = !cfg_mode[1] || (burst_period == 16'd0) || (burst_len == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ">=" keeps a shortened period/length from letting the counter run away.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        invert  = 1'b0;
        if (in_valid) begin
            if (burst_off) begin
                state_d = CLEAN;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    CLEAN: begin
                        if (cnt_inc >= {1'b0, burst_period}) begin
                            state_d = BURST;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[15:0];
                        end
                    end
                    BURST: begin
                        invert = 1'b1;
                        if (cnt_inc >= {9'd0, burst_len}) begin
                            state_d = CLEAN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[15:0];
                        end
                    end
                    default: begin
                        state_d = CLEAN;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    assign burst_state = state_q;

    // Stage 1
    logic                 s1_valid;
    logic [DATA_W-1:0]    s1_re;
    logic [DATA_W-1:0]    s1_im;
    logic signed [NW-1:0] s1_noise_re;
    logic signed [NW-1:0] s1_noise_im;
    logic                 s1_inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_re       <= '0;
            s1_im       <= '0;
            s1_noise_re <= '0;
            s1_noise_im <= '0;
            s1_inv      <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_re       <= in_re;
                s1_im       <= in_im;
                s1_noise_re <= cfg_mode[0] ? noise_re_sh : '0;
                s1_noise_im <= cfg_mode[0] ? noise_im_sh : '0;
                s1_inv      <= invert;
            end
        end
    end

    function automatic logic [DATA_W-1:0] saturate(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] max_v;
        logic signed [SW-1:0] min_v;
        max_v = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        min_v = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > max_v) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end else if (v < min_v) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end
        return v[DATA_W-1:0];
    endfunction

    // The most-negative code has no positive twin, so it clips to the maximum.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
        return -v;
    endfunction

    // Stage 2
    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    logic [DATA_W-1:0]    sat_re;
    logic [DATA_W-1:0]    sat_im;
    logic [DATA_W-1:0]    res_re;
    logic [DATA_W-1:0]    res_im;

    assign sum_re = {{(SW-DATA_W){s1_re[DATA_W-1]}}, s1_re} + {s1_noise_re[NW-1], s1_noise_re};
    assign sum_im = {{(SW-DATA_W){s1_im[DATA_W-1]}}, s1_im} + {s1_noise_im[NW-1], s1_noise_im};
    assign sat_re = saturate(sum_re);
    assign sat_im = saturate(sum_im);
    assign res_re = s1_inv ? negate(sat_re) : sat_re;
    assign res_im = s1_inv ? negate(sat_im) : sat_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_re <= res_re;
                out_im <= res_im;
            end
        end
    end

    // Statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_count   <= '0;
            burst_count <= '0;
        end else begin
            if (in_valid && (sym_count != '1)) begin
                sym_count <= sym_count + 32'd1;
            end
            if (s1_valid && s1_inv && (burst_count != '1)) begin
                burst_count <= burst_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_channel_model.sv
// Bench for channel_model: directed scenarios plus randomized segments checked
// against an integer-arithmetic reference model with an expected-output queue.
`timescale 1ns/1ps

module tb_channel_model;

    localparam int          DATA_W = 16;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_re = '0;
    logic [DATA_W-1:0] in_im = '0;
    logic [1:0]        cfg_mode = 2'd0;
    logic [3:0]        noise_shift = 4'd0;
    logic [15:0]       burst_period = 16'd0;
    logic [7:0]        burst_len = 8'd0;
    logic              out_valid;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [31:0]       sym_count;
    logic [15:0]       burst_count;
    logic              burst_state;

    channel_model #(.DATA_W(DATA_W), .SEED(SEED)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_re(in_re),
        .in_im(in_im),
        .cfg_mode(cfg_mode),
        .noise_shift(noise_shift),
        .burst_period(burst_period),
        .burst_len(burst_len),
        .out_valid(out_valid),
        .out_re(out_re),
        .out_im(out_im),
        .sym_count(sym_count),
        .burst_count(burst_count),
        .burst_state(burst_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Each entry: {inverted, re, im}
    logic [2*DATA_W:0] exp_q[$];
    logic [15:0]       m_lfsr = SEED;
    int                m_pos = 0;
    logic              m_prev_v = 1'b0;
    int                exp_sym = 0;
    int                exp_burst = 0;
    logic [15:0]       last_re = '0;
    logic [15:0]       last_im = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int neg16(input int v);
        return (v == -32768) ? 32767 : -v;
    endfunction

    // Burst position within one period+length cycle decides inversion.
    function automatic bit next_inverted();
        int p;
        int l;
        p = int'(burst_period);
        l = int'(burst_len);
        if (cfg_mode < 2'd2 || p == 0 || l == 0) return 1'b0;
        return (m_pos % (p + l)) >= p;
    endfunction

    task automatic model_push(input logic [15:0] re, input logic [15:0] im);
        int  nr;
        int  ni;
        int  vr;
        int  vi;
        int  sh;
        bit  inv;
        sh = (noise_shift > 4'd8) ? 8 : int'(noise_shift);
        nr = $signed(m_lfsr[15:8]);
        ni = $signed(m_lfsr[7:0]);
        nr = nr * (1 << sh);
        ni = ni * (1 << sh);
        vr = $signed(re);
        vi = $signed(im);
        if (cfg_mode == 2'd1 || cfg_mode == 2'd3) begin
            vr = sat16(vr + nr);
            vi = sat16(vi + ni);
        end
        inv = next_inverted();
        if (cfg_mode < 2'd2 || burst_period == 16'd0 || burst_len == 8'd0) m_pos = 0;
        else m_pos++;
        if (inv) begin
            vr = neg16(vr);
            vi = neg16(vi);
        end
        exp_q.push_back({inv, vr[15:0], vi[15:0]});
        exp_sym++;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    // Present one cycle of input, then check everything visible after the edge.
    task automatic step(input logic v, input logic [15:0] re, input logic [15:0] im);
        logic [2*DATA_W:0] e;
        in_valid = v;
        in_re    = re;
        in_im    = im;
        if (v) model_push(re, im);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_prev_v));
        if (m_prev_v) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                if (e[2*DATA_W]) exp_burst++;
                chk("out_re", 32'(out_re), 32'(e[2*DATA_W-1:DATA_W]));
                chk("out_im", 32'(out_im), 32'(e[DATA_W-1:0]));
                last_re = out_re;
                last_im = out_im;
            end
        end
        chk("sym_count", sym_count, 32'(exp_sym));
        chk("burst_count", 32'(burst_count), 32'(exp_burst));
        m_prev_v = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_re", 32'(out_re), 32'd0);
        chk("rst_out_im", 32'(out_im), 32'd0);
        chk("rst_sym_count", sym_count, 32'd0);
        chk("rst_burst_count", 32'(burst_count), 32'd0);
        chk("rst_burst_state", 32'(burst_state), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_lfsr = SEED;
        m_pos = 0;
        exp_q.delete();
        m_prev_v = 1'b0;
        exp_sym = 0;
        exp_burst = 0;
        idle(3);
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [3:0] s, input logic [15:0] p,
                           input logic [7:0] l);
        cfg_mode     = m;
        noise_shift  = s;
        burst_period = p;
        burst_len    = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  saved_mode;
        logic [15:0] d_re;
        logic [15:0] d_im;

        do_reset();

        // Bypass single pulse
        set_cfg(2'd0, 4'd0, 16'd0, 8'd0);
        step(1'b1, 16'h4000, 16'hC000);
        step(1'b0, 16'h0, 16'h0);
        chk("bypass_re", 32'(last_re), 32'h4000);
        chk("bypass_im", 32'(last_im), 32'hC000);
        chk("bypass_sym", sym_count, 32'd1);
        idle(2);

        // Noise from the seed with saturation
        do_reset();
        set_cfg(2'd1, 4'd8, 16'd0, 8'd0);
        step(1'b1, 16'h8000, 16'h0000);
        step(1'b0, 16'h0, 16'h0);
        chk("noise_sat_re", 32'(last_re), 32'h8000);
        chk("noise_sat_im", 32'(last_im), 32'hE100);

        // Burst pattern period 4, length 2
        do_reset();
        set_cfg(2'd2, 4'd0, 16'd4, 8'd2);
        for (int i = 0; i <= 12; i++) begin
            step(i < 12, 16'h1000, 16'h0000);
            if (i >= 1) begin
                chk("burst_pattern", 32'(last_re),
                    (i == 5 || i == 6 || i == 11 || i == 12) ? 32'hF000 : 32'h1000);
            end
        end
        chk("burst_total", 32'(burst_count), 32'd4);
        idle(2);

        // Negation of the most-negative value
        do_reset();
        set_cfg(2'd2, 4'd0, 16'd1, 8'd1);
        step(1'b1, 16'h1000, 16'h0000);
        step(1'b1, 16'h8000, 16'h0000);
        step(1'b0, 16'h0, 16'h0);
        chk("neg_edge_re", 32'(last_re), 32'h7FFF);
        idle(1);

        // Bubbles, noise active so LFSR advance shows in later outputs
        do_reset();
        set_cfg(2'd1, 4'd3, 16'd0, 8'd0);
        step(1'b1, 16'h0100, 16'h0200);
        step(1'b0, 16'h0, 16'h0);
        step(1'b1, 16'h0300, 16'h0400);
        step(1'b1, 16'h0500, 16'h0600);
        idle(2);
        chk("bubble_sym", sym_count, 32'd3);
        step(1'b1, 16'h0000, 16'h0000);
        idle(2);

        // Reset in the middle of a burst with symbols in flight
        do_reset();
        set_cfg(2'd2, 4'd0, 16'd1, 8'd1);
        step(1'b1, 16'h2000, 16'h1000);
        step(1'b1, 16'h2000, 16'h1000);
        step(1'b1, 16'h2000, 16'h1000);
        chk("pre_reset_state", 32'(burst_state), 32'(next_inverted()));
        do_reset();
        set_cfg(2'd3, 4'd0, 16'd1, 8'd1);
        step(1'b1, 16'h0000, 16'h0000);
        step(1'b0, 16'h0, 16'h0);
        chk("post_reset_re", 32'(last_re), 32'hFFAC);
        chk("post_reset_im", 32'(last_im), 32'hFFE1);
        chk("post_reset_burst", 32'(burst_count), 32'd0);
        idle(2);

        // Randomized segments; each starts with a bypass symbol to return to CLEAN
        for (int seg = 0; seg < 20; seg++) begin
            set_cfg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    16'($urandom_range(0, 5)), 8'($urandom_range(0, 3)));
            saved_mode = cfg_mode;
            cfg_mode = 2'd0;
            step(1'b1, 16'($urandom), 16'($urandom));
            cfg_mode = saved_mode;
            for (int i = 0; i < 30; i++) begin
                case ($urandom_range(0, 3))
                    0: d_re = 16'h8000;
                    1: d_re = 16'h7FFF;
                    default: d_re = 16'($urandom);
                endcase
                d_im = 16'($urandom);
                step($urandom_range(0, 3) != 0, d_re, d_im);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
